packet_sum_accumulator: RTL
===========================

Name: packet_sum_accumulator

Overview:
- Downstream consumer of the packet adder's sum stream (valid/ready, sum, last).
- Accumulates per-beat sums across a packet and counts the beats.
- On the last beat, emits one result record per packet: total, beat count, overflow flag.
- Sits between the adder pipeline and packet-level statistics/reporting logic.

Parameters:
- WIDTH, 8, adder operand width; input sum is WIDTH+1 bits.
- ACC_W, 16, accumulator/result total width; must be >= WIDTH+1.
- CNT_W, 8, beat counter width.
- MAX_BEATS, 16, maximum beats per packet; used only when PKT_ACC_MAXLEN_EN is defined; 1 <= MAX_BEATS <= 2^CNT_W-1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat valid from the adder.
- in_ready  output  1  block can accept a beat.
- in_sum  input  WIDTH+1  beat sum.
- in_last  input  1  final beat of the packet.
- out_valid  output  1  result record valid.
- out_ready  input  1  downstream accepts the record.
- out_total  output  ACC_W  packet total, modulo 2^ACC_W.
- out_beats  output  CNT_W  beats included in out_total.
- out_overflow  output  1  accumulator wrapped during the packet.
- out_err  output  1  packet truncated at MAX_BEATS (feature only; otherwise 0).

Behaviour:
- Reset: one clock, synchronous, active-high (rst). While rst=1 at a clk edge, all state clears.
  - out_valid=0, out_total=0, out_beats=0, out_overflow=0, out_err=0.
  - Accumulator=0, counter=0, FSM=IDLE.
  - Reset mid-packet discards the partial packet and any pending result.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A record is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). Stalls apply to every beat, not only last beats.
- Output register: a single-entry result register.
  - Once out_valid=1, all out_* fields hold stable until consumed.
  - Consume and reload in the same cycle is legal: a new last beat replaces the record and out_valid stays 1.
- Accumulation (working accumulator acc[ACC_W-1:0], counter cnt):
  - Accepted non-last beat: acc <= acc + zero-extended in_sum (mod 2^ACC_W).
    - cnt <= cnt+1, saturating at 2^CNT_W-1.
    - Sticky ovf set if the add carries out of ACC_W.
  - Accepted last beat: result register loads acc+in_sum, cnt+1 (saturating), and ovf|carry.
    - out_valid=1 on the next cycle (latency 1).
    - acc, cnt and ovf clear in the same cycle, so the next beat starts a fresh packet with no bubble.
- FSM:
  - IDLE: no beats held. Accepted non-last beat -> ACCUM; accepted last beat -> IDLE (single-beat packet).
  - ACCUM: accepted last beat -> IDLE.
  - DROP: exists only with the feature; see Optional Feature.
- Boundaries:
  - in_sum=2^(WIDTH+1)-1 on every beat accumulates without truncating the input.
  - Beats are never lost while in_ready=0; upstream must hold them.
  - out_ready is ignored while out_valid=0.

Optional Feature:
- Macro: PKT_ACC_MAXLEN_EN.
- Defined:
  - In IDLE/ACCUM, an accepted beat that makes cnt == MAX_BEATS with in_last=0 closes the packet as if last: record loads with out_err=1.
  - FSM -> DROP. In DROP, in_ready=1 unconditionally; beats are accepted and discarded until an accepted in_last beat, then FSM -> IDLE.
  - A MAX_BEATS-th beat carrying in_last=1 is a normal packet with out_err=0.
- Undefined:
  - No DROP state; packets of any length accumulate.
  - cnt saturates at 2^CNT_W-1; out_err tied to 0.

Test Plan:
- Beats 10,20,30, last on 30, out_ready=1 -> one cycle later out_valid=1, out_total=60, out_beats=3, out_overflow=0.
- Single beat 511, last=1 -> out_total=511, out_beats=1; back-to-back next packet 5,6(last) with no idle cycle -> out_total=11, out_beats=2.
- Record pending with out_ready=0 for 5 cycles, new beats offered -> in_ready=0, record stable; out_ready=1 -> record consumed, next beat accepted that cycle.
- ACC_W=10, beats 511,511,511(last) -> out_total=509, out_beats=3, out_overflow=1; next packet 1(last) -> out_overflow=0.
- rst=1 after 2 beats of 7, then packet 4(last) -> out_total=4, out_beats=1; all outputs 0 during reset.
- MAX_BEATS=4, six beats of 1, last on 6th:
  - With PKT_ACC_MAXLEN_EN -> record total=4, beats=4, err=1 after 4th beat; beats 5-6 dropped; following packet 9(last) gives total=9, err=0.
  - Without the macro -> total=6, beats=6, err=0.

Source files
------------

// File: rtl/packet_sum_accumulator.sv
// Packet sum accumulator: totals per-beat sums and emits one record per packet.
// Define PKT_ACC_MAXLEN_EN to truncate packets at MAX_BEATS and drop the remainder.
module packet_sum_accumulator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH:0]     in_sum,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_total,
  output logic [CNT_W-1:0]   out_beats,
  output logic               out_overflow,
  output logic               out_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
`ifdef PKT_ACC_MAXLEN_EN
  localparam logic [1:0] DROP  = 2'd2;
`endif

  if (ACC_W < WIDTH + 1 || MAX_BEATS < 1 || MAX_BEATS > (2 ** CNT_W) - 1) begin : g_bad_params
    $error("packet_sum_accumulator: illegal parameter combination");
  end

  logic [1:0]       state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ovf, ovf_d;
  logic             out_valid_d;
  logic [ACC_W-1:0] out_total_d;
  logic [CNT_W-1:0] out_beats_d;
  logic             out_overflow_d;
  logic [ACC_W:0]   sum_c;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             dropping;
  logic             trunc;
  logic             close;

`ifdef PKT_ACC_MAXLEN_EN
  logic out_err_d;
  assign dropping = (state == DROP);
  assign trunc    = !in_last && (cnt_inc == CNT_W'(MAX_BEATS));
`else
  assign dropping = 1'b0;
  assign trunc    = 1'b0;
  assign out_err  = 1'b0;
`endif

  // Drop mode swallows beats regardless of the result register.
  assign in_ready = dropping || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sum_c    = {1'b0, acc} + (ACC_W+1)'(in_sum);
  assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign close    = in_last || trunc;

  // Next-state and datapath decode.
  always_comb begin
    state_d        = state;
    acc_d          = acc;
    cnt_d          = cnt;
    ovf_d          = ovf;
    out_valid_d    = out_valid && !out_ready;
    out_total_d    = out_total;
    out_beats_d    = out_beats;
    out_overflow_d = out_overflow;
`ifdef PKT_ACC_MAXLEN_EN
    out_err_d      = out_err;
`endif
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (close) begin
            out_valid_d    = 1'b1;
            out_total_d    = sum_c[ACC_W-1:0];
            out_beats_d    = cnt_inc;
            out_overflow_d = ovf || sum_c[ACC_W];
            acc_d          = '0;
            cnt_d          = '0;
            ovf_d          = 1'b0;
            state_d        = IDLE;
`ifdef PKT_ACC_MAXLEN_EN
            out_err_d      = trunc;
            if (trunc) state_d = DROP;
`endif
          end else begin
            acc_d   = sum_c[ACC_W-1:0];
            cnt_d   = cnt_inc;
            ovf_d   = ovf || sum_c[ACC_W];
            state_d = ACCUM;
          end
        end
      end
`ifdef PKT_ACC_MAXLEN_EN
      DROP: begin
        if (accept && in_last) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_total    <= '0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
`ifdef PKT_ACC_MAXLEN_EN
      out_err      <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      acc          <= acc_d;
      cnt          <= cnt_d;
      ovf          <= ovf_d;
      out_valid    <= out_valid_d;
      out_total    <= out_total_d;
      out_beats    <= out_beats_d;
      out_overflow <= out_overflow_d;
`ifdef PKT_ACC_MAXLEN_EN
      out_err      <= out_err_d;
`endif
    end
  end

endmodule
